apb_to_ahbl: RTL and testbench

APB_TO_AHBL -- requirements
Module: apb_to_ahbl

---
 rtl/apb_to_ahbl_pkg.sv | 18 +
 rtl/apb_to_ahbl.sv | 108 ++++++++++
 tb/tb_apb_to_ahbl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/apb_to_ahbl_pkg.sv
// rtl/apb_to_ahbl_pkg.sv - shared bus-fabric constants and APB-to-AHB-Lite bridge state encoding
package apb_to_ahbl_pkg;

   // Bridge sequencing: idle, AHB address phase, AHB data phase, APB completion
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_APHASE = 2'd1,
      S_DPHASE = 2'd2,
      S_RESP   = 2'd3
   } bridge_state_e;

   localparam logic [1:0] HTRANS_IDLE     = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ   = 2'b10;
   localparam logic [2:0] HSIZE_WORD      = 3'b010;
   localparam logic [2:0] HBURST_SINGLE   = 3'b000;
   localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

endpackage

// File: rtl/apb_to_ahbl.sv
// rtl/apb_to_ahbl.sv - APB slave to AHB-Lite master bridge, one single-word transfer per APB access
module apb_to_ahbl
   import apb_to_ahbl_pkg::*;
#(
   parameter int                 W_PADDR    = 16,
   parameter int                 W_HADDR    = 32,
   parameter int                 W_DATA     = 32,
   parameter logic [W_HADDR-1:0] HADDR_BASE = '0,
   parameter int                 FULL_RESET = 1
) (
   input  logic               clk,
   input  logic               rst,

   input  logic               apbs_psel,
   input  logic               apbs_penable,
   input  logic               apbs_pwrite,
   input  logic [W_PADDR-1:0] apbs_paddr,
   input  logic [W_DATA-1:0]  apbs_pwdata,
   output logic               apbs_pready,
   output logic               apbs_pslverr,
   output logic [W_DATA-1:0]  apbs_prdata,

   output logic [W_HADDR-1:0] ahblm_haddr,
   output logic               ahblm_hwrite,
   output logic [1:0]         ahblm_htrans,
   output logic [2:0]         ahblm_hsize,
   output logic [2:0]         ahblm_hburst,
   output logic [3:0]         ahblm_hprot,
   output logic               ahblm_hmastlock,
   output logic [W_DATA-1:0]  ahblm_hwdata,
   input  logic               ahblm_hready,
   input  logic               ahblm_hresp,
   input  logic [W_DATA-1:0]  ahblm_hrdata
);

   bridge_state_e      state_q, state_d;
   logic [W_HADDR-1:0] haddr_q;
   logic               hwrite_q;
   logic [W_DATA-1:0]  hwdata_q;
   logic [W_DATA-1:0]  prdata_q;
   logic               pslverr_q;

   logic start_xfer;
   logic dphase_done;

   // Only the APB access phase starts a transfer; the setup phase is ignored
   assign start_xfer  = (state_q == S_IDLE) && apbs_psel && apbs_penable;
   // The error response's first (hready low) cycle is waited through like any wait state
   assign dphase_done = (state_q == S_DPHASE) && ahblm_hready;

   // Next-state: once started, the transfer runs to completion regardless of psel/penable
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (start_xfer)   state_d = S_APHASE;
         S_APHASE: if (ahblm_hready) state_d = S_DPHASE;
         S_DPHASE: if (ahblm_hready) state_d = S_RESP;
         S_RESP:                     state_d = S_IDLE;
         default:                    state_d = S_IDLE;
      endcase
   end

   // Control flops: state and the slave-error flag always reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         pslverr_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (dphase_done) begin
            pslverr_q <= ahblm_hresp;
         end
      end
   end

   // Datapath flops: request captured at access start, read data at end of data phase
   always_ff @(posedge clk) begin
      if (rst && (FULL_RESET != 0)) begin
         haddr_q  <= '0;
         hwrite_q <= 1'b0;
         hwdata_q <= '0;
         prdata_q <= '0;
      end else begin
         if (start_xfer) begin
            haddr_q  <= HADDR_BASE | W_HADDR'(apbs_paddr);
            hwrite_q <= apbs_pwrite;
            hwdata_q <= apbs_pwdata;
         end
         if (dphase_done) begin
            prdata_q <= ahblm_hrdata;
         end
      end
   end

   assign ahblm_htrans    = (state_q == S_APHASE) ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign ahblm_haddr     = haddr_q;
   assign ahblm_hwrite    = hwrite_q;
   assign ahblm_hwdata    = hwdata_q;
   assign ahblm_hsize     = HSIZE_WORD;
   assign ahblm_hburst    = HBURST_SINGLE;
   assign ahblm_hprot     = HPROT_DATA_PRIV;
   assign ahblm_hmastlock = 1'b0;

   assign apbs_pready  = (state_q == S_RESP);
   assign apbs_pslverr = pslverr_q;
   assign apbs_prdata  = prdata_q;

endmodule

// File: tb/tb_apb_to_ahbl.sv
// tb/tb_apb_to_ahbl.sv - self-checking bench for the APB to AHB-Lite bridge
module tb_apb_to_ahbl;

   logic        clk = 1'b0;
   logic        rst;
   logic        psel, penable, pwrite;
   logic [15:0] paddr;
   logic [31:0] pwdata;
   logic        pready, pslverr;
   logic [31:0] prdata;
   logic [31:0] haddr;
   logic        hwrite;
   logic [1:0]  htrans;
   logic [2:0]  hsize, hburst;
   logic [3:0]  hprot;
   logic        hmastlock;
   logic [31:0] hwdata;
   logic        hready, hresp;
   logic [31:0] hrdata;

   int total = 0;
   int bad = 0;
   int acc_cnt = 0;
   int exp_acc = 0;

   typedef struct {
      logic        pwrite;
      logic [15:0] paddr;
      logic [31:0] pwdata;
      int          aw;
      int          dw;
      logic [31:0] hrdata;
      logic        hresp;
      logic [31:0] exp_haddr;
      logic [31:0] exp_prdata;
      logic        exp_slverr;
      int          exp_lat;
   } vec_t;

   vec_t tbl[6];

   apb_to_ahbl #(
      .W_PADDR(16), .W_HADDR(32), .W_DATA(32),
      .HADDR_BASE(32'h4000_0000), .FULL_RESET(1)
   ) dut (
      .clk(clk), .rst(rst),
      .apbs_psel(psel), .apbs_penable(penable), .apbs_pwrite(pwrite),
      .apbs_paddr(paddr), .apbs_pwdata(pwdata),
      .apbs_pready(pready), .apbs_pslverr(pslverr), .apbs_prdata(prdata),
      .ahblm_haddr(haddr), .ahblm_hwrite(hwrite), .ahblm_htrans(htrans),
      .ahblm_hsize(hsize), .ahblm_hburst(hburst), .ahblm_hprot(hprot),
      .ahblm_hmastlock(hmastlock), .ahblm_hwdata(hwdata),
      .ahblm_hready(hready), .ahblm_hresp(hresp), .ahblm_hrdata(hrdata)
   );

   always #5 clk = ~clk;

   // Count AHB address phases accepted by the slave
   always @(negedge clk) begin
      if (!rst && htrans == 2'b10 && hready) acc_cnt++;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v);
      int   aw_left, dw_left, nonseq, lat;
      logic adone, done;
      aw_left = v.aw; dw_left = v.dw; nonseq = 0; lat = 0; adone = 1'b0; done = 1'b0;
      psel = 1'b1; penable = 1'b0; pwrite = v.pwrite; paddr = v.paddr; pwdata = v.pwdata;
      hready = 1'b1; hresp = 1'b0;
      chk("setup_htrans", 32'(htrans), 32'h0);
      chk("setup_pready", 32'(pready), 32'h0);
      @(posedge clk); #1;
      penable = 1'b1;
      chk("access_htrans", 32'(htrans), 32'h0);
      exp_acc++;
      for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
         @(posedge clk); #1;
         if (pready) begin
            lat = cyc; done = 1'b1;
            chk("latency", 32'(lat), 32'(v.exp_lat));
            chk("pslverr", 32'(pslverr), 32'(v.exp_slverr));
            if (!v.pwrite) chk("prdata", prdata, v.exp_prdata);
            hready = 1'b1; hresp = 1'b0; hrdata = 32'h0BAD_0BAD;
         end else if (htrans == 2'b10) begin
            nonseq++;
            chk("haddr", haddr, v.exp_haddr);
            chk("hwrite_aphase", 32'(hwrite), 32'(v.pwrite));
            if (aw_left > 0) begin
               hready = 1'b0; aw_left--;
            end else begin
               hready = 1'b1; adone = 1'b1;
            end
         end else if (adone) begin
            if (v.pwrite) chk("hwdata", hwdata, v.pwdata);
            chk("hwrite_dphase", 32'(hwrite), 32'(v.pwrite));
            hresp = v.hresp; hrdata = v.hrdata;
            if (dw_left > 0) begin
               hready = 1'b0; dw_left--;
            end else begin
               hready = 1'b1;
            end
         end else begin
            chk("stalled_htrans", 32'(htrans), 32'h2);
         end
      end
      if (!done) chk("pready_timeout", 32'h0, 32'h1);
      chk("nonseq_cycles", 32'(nonseq), 32'(v.aw + 1));
      @(posedge clk); #1;
      chk("pready_one_cycle", 32'(pready), 32'h0);
      chk("post_htrans", 32'(htrans), 32'h0);
      psel = 1'b0; penable = 1'b0;
   endtask

   initial begin
      vec_t v;
      tbl[0] = '{1'b0, 16'h0040, 32'h0,         0, 0, 32'hDEAD_BEEF, 1'b0, 32'h4000_0040, 32'hDEAD_BEEF, 1'b0, 3};
      tbl[1] = '{1'b1, 16'h1234, 32'h1234_5678, 0, 2, 32'h0,         1'b0, 32'h4000_1234, 32'h0,         1'b0, 5};
      tbl[2] = '{1'b0, 16'h0008, 32'h0,         0, 1, 32'h0000_0000, 1'b1, 32'h4000_0008, 32'h0000_0000, 1'b1, 4};
      tbl[3] = '{1'b0, 16'hFFFC, 32'h0,         3, 0, 32'hA5A5_5A5A, 1'b0, 32'h4000_FFFC, 32'hA5A5_5A5A, 1'b0, 6};
      tbl[4] = '{1'b1, 16'h0000, 32'h8765_4321, 1, 1, 32'h0,         1'b1, 32'h4000_0000, 32'h0,         1'b1, 5};
      tbl[5] = '{1'b0, 16'h8001, 32'h0,         0, 0, 32'h0000_0001, 1'b0, 32'h4000_8001, 32'h0000_0001, 1'b0, 3};

      rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
      hready = 1'b1; hresp = 1'b0; hrdata = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_htrans", 32'(htrans), 32'h0);
      chk("rst_pready", 32'(pready), 32'h0);
      chk("rst_pslverr", 32'(pslverr), 32'h0);
      chk("rst_haddr", haddr, 32'h0);
      chk("rst_hwrite", 32'(hwrite), 32'h0);
      chk("rst_hwdata", hwdata, 32'h0);
      chk("rst_prdata", prdata, 32'h0);
      chk("hsize", 32'(hsize), 32'h2);
      chk("hburst", 32'(hburst), 32'h0);
      chk("hprot", 32'(hprot), 32'h3);
      chk("hmastlock", 32'(hmastlock), 32'h0);
      rst = 1'b0;

      // Table entries run back to back: each setup phase follows the previous completion
      for (int i = 0; i < 6; i++) run_vec(tbl[i]);

      // psel/penable dropped during the address phase: transfer still completes
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0100; pwdata = 32'hCAFE_F00D; hready = 1'b1;
      @(posedge clk); #1;
      penable = 1'b1;
      @(posedge clk); #1;
      chk("drop_htrans", 32'(htrans), 32'h2);
      chk("drop_haddr", haddr, 32'h4000_0100);
      psel = 1'b0; penable = 1'b0; hready = 1'b1; exp_acc++;
      @(posedge clk); #1;
      chk("drop_dphase_htrans", 32'(htrans), 32'h0);
      chk("drop_hwdata", hwdata, 32'hCAFE_F00D);
      chk("drop_hwrite", 32'(hwrite), 32'h1);
      @(posedge clk); #1;
      chk("drop_pready", 32'(pready), 32'h1);
      chk("drop_pslverr", 32'(pslverr), 32'h0);
      @(posedge clk); #1;
      chk("drop_pready_end", 32'(pready), 32'h0);

      // Reset asserted during the data phase abandons the transfer
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0010; hready = 1'b1; hresp = 1'b0;
      @(posedge clk); #1;
      penable = 1'b1;
      @(posedge clk); #1;
      chk("mrst_aphase", 32'(htrans), 32'h2);
      hready = 1'b1; exp_acc++;
      @(posedge clk); #1;
      chk("mrst_dphase_htrans", 32'(htrans), 32'h0);
      chk("mrst_dphase_pready", 32'(pready), 32'h0);
      hready = 1'b0; hrdata = 32'h1111_2222; rst = 1'b1;
      @(posedge clk); #1;
      chk("mrst_htrans", 32'(htrans), 32'h0);
      chk("mrst_pready", 32'(pready), 32'h0);
      chk("mrst_pslverr", 32'(pslverr), 32'h0);
      chk("mrst_prdata", prdata, 32'h0);
      rst = 1'b0; psel = 1'b0; penable = 1'b0; hready = 1'b1;
      @(posedge clk); #1;
      chk("mrst_idle_htrans", 32'(htrans), 32'h0);
      chk("mrst_idle_pready", 32'(pready), 32'h0);

      v = '{1'b0, 16'h0020, 32'h0, 0, 0, 32'h600D_F00D, 1'b0, 32'h4000_0020, 32'h600D_F00D, 1'b0, 3};
      run_vec(v);

      @(posedge clk); #1;
      chk("accepted_transfers", 32'(acc_cnt), 32'(exp_acc));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
